// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared widths, starvation limit and FSM state encoding for sram_arbiter
package sram_arb_pkg;

  localparam int ADDR_W_DEF   = 32;
  localparam int DATA_W_DEF   = 32;
  localparam int LINE_W_DEF   = 64;
  localparam int MAX_WAIT_DEF = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_e;

endpackage

// File: rtl/sram_arb_if.sv
// rtl/sram_arb_if.sv - requester ports and SRAM controller bus seen by sram_arbiter
interface sram_arb_if
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LINE_W = LINE_W_DEF
) ();

  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              done0;
  logic [LINE_W-1:0] rdata0;

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              done1;
  logic [LINE_W-1:0] rdata1;

  logic              sram_wr_en;
  logic              sram_rd_en;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [LINE_W-1:0] sram_rdata;
  logic              sram_ready;

  modport master (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, sram_rdata, sram_ready,
    output done0, rdata0, done1, rdata1, sram_wr_en, sram_rd_en, sram_addr, sram_wdata
  );

  modport slave (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, sram_rdata, sram_ready,
    input  done0, rdata0, done1, rdata1, sram_wr_en, sram_rd_en, sram_addr, sram_wdata
  );

endinterface

// File: rtl/sram_arb_pick.sv
// rtl/sram_arb_pick.sv - grant selection; SRAM_ARB_RR_EN selects round-robin over fixed priority
module sram_arb_pick
  import sram_arb_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic       req0,
  input  logic       req1,
`ifdef SRAM_ARB_RR_EN
  input  logic       last_grant,
`else
  input  logic [1:0] win_cnt,
`endif
  output logic       gnt_valid,
  output logic       gnt_port
);

  always_comb begin
    gnt_valid = req0 | req1;
    gnt_port  = 1'b0;
`ifdef SRAM_ARB_RR_EN
    gnt_port  = req1 && (!req0 || !last_grant);
`else
    // port 1 overrides port 0 only once it has been passed over MAX_WAIT times
    gnt_port  = req1 && (!req0 || (int'(win_cnt) >= MAX_WAIT));
`endif
  end

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-port arbiter in front of the SRAM controller; SRAM_ARB_RR_EN selects round-robin
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int LINE_W   = LINE_W_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  sram_arb_if.master bus
);

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic              first_q, first_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [LINE_W-1:0] rdata0_q, rdata0_d;
  logic [LINE_W-1:0] rdata1_q, rdata1_d;
  logic              gnt_valid, gnt_port;
  logic              complete, active;
`ifdef SRAM_ARB_RR_EN
  logic              last_q, last_d;
`else
  logic [1:0]        win_q, win_d;
`endif

  sram_arb_pick #(.MAX_WAIT(MAX_WAIT)) u_pick (
    .req0      (bus.req0),
    .req1      (bus.req1),
`ifdef SRAM_ARB_RR_EN
    .last_grant(last_q),
`else
    .win_cnt   (win_q),
`endif
    .gnt_valid (gnt_valid),
    .gnt_port  (gnt_port)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    we_d     = we_q;
    first_d  = first_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    complete = 1'b0;
`ifdef SRAM_ARB_RR_EN
    last_d   = last_q;
`else
    win_d    = win_q;
`endif
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          state_d = BUSY;
          owner_d = gnt_port;
          first_d = 1'b1;
          we_d    = gnt_port ? bus.we1    : bus.we0;
          addr_d  = gnt_port ? bus.addr1  : bus.addr0;
          wdata_d = gnt_port ? bus.wdata1 : bus.wdata0;
`ifdef SRAM_ARB_RR_EN
          last_d  = gnt_port;
`else
          if (gnt_port)
            win_d = 2'd0;
          else if (bus.req1 && win_q != 2'd3)
            win_d = win_q + 2'd1;
`endif
        end
      end
      BUSY: begin
        first_d = 1'b0;
        // the controller idles with ready=1, so the first BUSY cycle cannot be completion
        if (!first_q && bus.sram_ready) begin
          complete = 1'b1;
          state_d  = RELEASE;
          if (owner_q)
            rdata1_d = bus.sram_rdata;
          else
            rdata0_d = bus.sram_rdata;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      first_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
`ifdef SRAM_ARB_RR_EN
      last_q   <= 1'b1;
`else
      win_q    <= 2'd0;
`endif
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      first_q  <= first_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
`ifdef SRAM_ARB_RR_EN
      last_q   <= last_d;
`else
      win_q    <= win_d;
`endif
    end
  end

  // enables stay up through RELEASE so the controller counter wraps to 0
  assign active         = (state_q == BUSY) || (state_q == RELEASE);
  assign bus.sram_wr_en = active & we_q;
  assign bus.sram_rd_en = active & ~we_q;
  assign bus.sram_addr  = addr_q;
  assign bus.sram_wdata = wdata_q;
  assign bus.done0      = complete & ~owner_q;
  assign bus.done1      = complete & owner_q;
  assign bus.rdata0     = bus.done0 ? bus.sram_rdata : rdata0_q;
  assign bus.rdata1     = bus.done1 ? bus.sram_rdata : rdata1_q;

endmodule
